// File: rtl/UART_MIKE_pkg.sv
// Shared types and constants for the UART_MIKE receive path.
package UART_MIKE_pkg;

   localparam int UART_RX_PARITY_NONE = 0;
   localparam int UART_RX_PARITY_EVEN = 1;
   localparam int UART_RX_PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } uart_rx_state_t;

   typedef enum logic [1:0] {
      UART_PAR_NONE = 2'd0,
      UART_PAR_EVEN = 2'd1,
      UART_PAR_ODD  = 2'd2
   } uart_parity_t;

endpackage

// File: rtl/uart_rx_baud_cnt.sv
// Loadable baud down-counter. A load arms either a half-period or a full-period
// interval; o_tick is high in the cycle before the edge that ends the interval.
module uart_rx_baud_cnt #(
   parameter int CLKS_PER_BIT = 16,
   parameter int HALF_LD      = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_half,
   output logic o_tick
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_V = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_V = CW'(HALF_LD);

   logic [CW-1:0] r_cnt;

   // Reload on request, otherwise count down and park at zero.
   always_ff @(posedge clk) begin
      if (rst)                r_cnt <= '0;
      else if (i_load)        r_cnt <= i_half ? HALF_V : FULL_V;
      else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
   end

   assign o_tick = (r_cnt == '0);
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, oversampling, parity and stop bits.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each
// sample point, with all sample timing delayed by one cycle.
module uart_rx_cfg
   import UART_MIKE_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_MODE  = UART_RX_PARITY_NONE,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   input  logic                  rx_flag_clr,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_flag,
   output logic                  parity_error,
   output logic                  frame_error,
   output logic                  overrun_error,
   output logic                  busy
);
   localparam int BCW = $clog2(DATA_WIDTH + 1);
   localparam uart_parity_t PAR = uart_parity_t'(PARITY_MODE);
`ifdef UART_RX_MAJORITY_EN
   localparam int HALF_LD = CLKS_PER_BIT / 2;
`else
   localparam int HALF_LD = CLKS_PER_BIT / 2 - 1;
`endif

   uart_rx_state_t        r_state, w_nxt;
   logic                  r_sync1, r_sync2, r_prev;
   logic [BCW-1:0]        r_bitcnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_par_err, r_frm_err, r_commit;
   logic                  w_samp, w_start_edge, w_tick;
   logic                  w_load, w_half, w_start_ok, w_shift, w_par_smp, w_stop_smp, w_last_stop;

   // Synchronizer plus edge-detect flop; preset high so reset never looks like a start.
   always_ff @(posedge clk) begin
      if (rst) {r_sync1, r_sync2, r_prev} <= 3'b111;
      else     {r_sync1, r_sync2, r_prev} <= {rx, r_sync1, r_sync2};
   end

`ifdef UART_RX_MAJORITY_EN
   logic r_prev2;
   // Extra history flop so the vote sees the line at sample-1, sample, sample+1.
   always_ff @(posedge clk) begin
      if (rst) r_prev2 <= 1'b1;
      else     r_prev2 <= r_prev;
   end
   assign w_samp = (r_sync2 & r_prev) | (r_sync2 & r_prev2) | (r_prev & r_prev2);
`else
   assign w_samp = r_sync2;
`endif

   assign w_start_edge = !r_sync2 && r_prev;
   assign busy         = (r_state != ST_IDLE);

   uart_rx_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT), .HALF_LD(HALF_LD)) u_baud (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_half (w_half),
      .o_tick (w_tick)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_nxt;
   end

   // Next-state and per-sample strobes.
   always_comb begin
      w_nxt       = r_state;
      w_load      = 1'b0;
      w_half      = 1'b0;
      w_start_ok  = 1'b0;
      w_shift     = 1'b0;
      w_par_smp   = 1'b0;
      w_stop_smp  = 1'b0;
      w_last_stop = 1'b0;
      case (r_state)
         ST_IDLE: if (w_start_edge) begin
            w_nxt  = ST_START;
            w_load = 1'b1;
            w_half = 1'b1;
         end
         ST_START: if (w_tick) begin
            if (w_samp) w_nxt = ST_IDLE;          // glitch: line back high mid-start
            else begin
               w_nxt      = ST_DATA;
               w_load     = 1'b1;
               w_start_ok = 1'b1;
            end
         end
         ST_DATA: if (w_tick) begin
            w_load  = 1'b1;
            w_shift = 1'b1;
            if (r_bitcnt == BCW'(DATA_WIDTH - 1))
               w_nxt = (PAR != UART_PAR_NONE) ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: if (w_tick) begin
            w_load    = 1'b1;
            w_par_smp = 1'b1;
            w_nxt     = ST_STOP;
         end
         ST_STOP: if (w_tick) begin
            w_load     = 1'b1;
            w_stop_smp = 1'b1;
            if (r_bitcnt == BCW'(STOP_BITS - 1)) begin
               w_last_stop = 1'b1;
               w_nxt       = w_samp ? ST_IDLE : ST_BREAK;
            end
         end
         ST_BREAK: if (r_sync2) w_nxt = ST_IDLE;   // hold off until the line recovers
         default: w_nxt = ST_IDLE;
      endcase
   end

   // Frame datapath: shift register, bit counter and in-flight error bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift   <= '0;
         r_bitcnt  <= '0;
         r_par_err <= 1'b0;
         r_frm_err <= 1'b0;
         r_commit  <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_bitcnt  <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
         end else if (w_shift) begin
            r_bitcnt <= (r_bitcnt == BCW'(DATA_WIDTH - 1)) ? '0 : r_bitcnt + 1'b1;
         end else if (w_stop_smp) begin
            r_bitcnt <= r_bitcnt + 1'b1;
         end
         if (w_shift)               r_shift   <= {w_samp, r_shift[DATA_WIDTH-1:1]};
         if (w_par_smp)             r_par_err <= (^r_shift) ^ w_samp ^ (PAR == UART_PAR_ODD);
         if (w_stop_smp && !w_samp) r_frm_err <= 1'b1;
         r_commit <= w_last_stop;
      end
   end

   // Host-visible holding registers; a commit overrides a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data       <= '0;
         rx_flag       <= 1'b0;
         parity_error  <= 1'b0;
         frame_error   <= 1'b0;
         overrun_error <= 1'b0;
      end else if (r_commit) begin
         rx_data       <= r_shift;
         rx_flag       <= 1'b1;
         parity_error  <= r_par_err;
         frame_error   <= r_frm_err;
         overrun_error <= rx_flag && !rx_flag_clr;
      end else if (rx_flag_clr) begin
         rx_flag       <= 1'b0;
         parity_error  <= 1'b0;
         frame_error   <= 1'b0;
         overrun_error <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: stimulus pushes expected output snapshots tagged with the
// cycle they must appear in; a monitor compares them on the falling edge.
module tb_uart_rx_cfg;
`ifdef UART_RX_MAJORITY_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic clk = 1'b0, rst = 1'b1;
   logic rx_a = 1'b1, rx_b = 1'b1, clr_a = 1'b0, clr_b = 1'b0;
   logic [7:0] data_a, data_b;
   logic flag_a, perr_a, ferr_a, oerr_a, busy_a;
   logic flag_b, perr_b, ferr_b, oerr_b, busy_b;

   // A: 8 bits, even parity, 1 stop.  B: 8 bits, no parity, 2 stops.
   uart_rx_cfg #(.DATA_WIDTH(8), .CLKS_PER_BIT(16), .PARITY_MODE(1), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .rx(rx_a), .rx_flag_clr(clr_a), .rx_data(data_a), .rx_flag(flag_a),
      .parity_error(perr_a), .frame_error(ferr_a), .overrun_error(oerr_a), .busy(busy_a));
   uart_rx_cfg #(.DATA_WIDTH(8), .CLKS_PER_BIT(16), .PARITY_MODE(0), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .rx(rx_b), .rx_flag_clr(clr_b), .rx_data(data_b), .rx_flag(flag_b),
      .parity_error(perr_b), .frame_error(ferr_b), .overrun_error(oerr_b), .busy(busy_b));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string      name;
      int         at;
      bit         dut;
      logic [12:0] v;   // {data, flag, perr, ferr, oerr, busy}
   } exp_t;

   exp_t q[$];
   int checks = 0, fails = 0;

   task automatic expect_at(input string nm, input int at, input bit d, input logic [7:0] dt,
                            input logic f, input logic p, input logic fe, input logic o, input logic b);
      exp_t e;
      e.name = nm; e.at = at; e.dut = d; e.v = {dt, f, p, fe, o, b};
      q.push_back(e);
   endtask

   // Monitor: compare every snapshot whose cycle has arrived.
   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            logic [12:0] act;
            e = q.pop_front();
            act = e.dut ? {data_b, flag_b, perr_b, ferr_b, oerr_b, busy_b}
                        : {data_a, flag_a, perr_a, ferr_a, oerr_a, busy_a};
            checks++;
            if (e.at != cyc) begin
               fails++;
               $display("FAIL %s: snapshot for cycle %0d seen late at %0d", e.name, e.at, cyc);
            end else if (act !== e.v) begin
               fails++;
               $display("FAIL %s @%0d: got data=%h flag/perr/ferr/oerr/busy=%b, want data=%h %b",
                        e.name, cyc, act[12:5], act[4:0], e.v[12:5], e.v[4:0]);
            end
         end
      end
   end

   function automatic logic [15:0] frm_a(input logic [7:0] d, input logic par);
      return {5'b0, 1'b1, par, d, 1'b0};
   endfunction
   function automatic logic [15:0] frm_b(input logic [7:0] d, input logic s2);
      return {5'b0, s2, 1'b1, d, 1'b0};
   endfunction

   // Drive n bits LSB first, 16 clocks each, starting at the current falling edge.
   task automatic send(input bit d, input logic [15:0] bits, input int n, input int clr_off);
      int t0;
      t0 = cyc + 1;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 16; j++) begin
            if (d) rx_b = bits[i]; else rx_a = bits[i];
            clr_a = (clr_off >= 0) && (cyc == t0 + clr_off);
            @(negedge clk);
         end
      end
      clr_a = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int t0;

   initial begin
      // Reset state
      idle(2);
      expect_at("reset_a", cyc + 1, 0, 8'h00, 0, 0, 0, 0, 0);
      expect_at("reset_b", cyc + 1, 1, 8'h00, 0, 0, 0, 0, 0);
      @(negedge clk); rst = 1'b0;
      idle(5);

      // 0xA5 with good even parity: exact commit timing
      t0 = cyc + 1;
      expect_at("a5_before", t0 + 170 + LAT, 0, 8'h00, 0, 0, 0, 0, 0);
      expect_at("a5_commit", t0 + 171 + LAT, 0, 8'hA5, 1, 0, 0, 0, 0);
      send(0, frm_a(8'hA5, 1'b0), 11, -1); rx_a = 1'b1; idle(4);
      clr_a = 1'b1; expect_at("a5_clr", cyc + 1, 0, 8'hA5, 0, 0, 0, 0, 0);
      @(negedge clk); clr_a = 1'b0; idle(4);

      // 0x3C with wrong parity bit
      t0 = cyc + 1;
      expect_at("3c_parerr", t0 + 171 + LAT, 0, 8'h3C, 1, 1, 0, 0, 0);
      send(0, frm_a(8'h3C, 1'b1), 11, -1); rx_a = 1'b1; idle(4);
      clr_a = 1'b1; expect_at("3c_clr", cyc + 1, 0, 8'h3C, 0, 0, 0, 0, 0);
      @(negedge clk); clr_a = 1'b0; idle(4);

      // 4-cycle low glitch: start detected, then rejected at the start sample
      t0 = cyc + 1;
      expect_at("glitch_start", t0 + 5, 0, 8'h3C, 0, 0, 0, 0, 1);
      expect_at("glitch_idle", t0 + 12 + LAT, 0, 8'h3C, 0, 0, 0, 0, 0);
      rx_a = 1'b0; idle(4); rx_a = 1'b1; idle(30);

      // B: second stop bit low, then line held low
      t0 = cyc + 1;
      expect_at("b_frame_err", t0 + 171 + LAT, 1, 8'h5A, 1, 0, 1, 0, 1);
      expect_at("b_break_hold", t0 + 261, 1, 8'h5A, 1, 0, 1, 0, 1);
      send(1, frm_b(8'h5A, 1'b0), 11, -1); idle(100);
      rx_b = 1'b1;
      expect_at("b_break_exit", cyc + 6, 1, 8'h5A, 1, 0, 1, 0, 0);
      idle(10);

      // Overrun: 0x11 then 0x22 without clearing
      t0 = cyc + 1;
      expect_at("ovr_first", t0 + 171 + LAT, 0, 8'h11, 1, 0, 0, 0, 0);
      send(0, frm_a(8'h11, 1'b0), 11, -1); rx_a = 1'b1; idle(4);
      t0 = cyc + 1;
      expect_at("ovr_second", t0 + 171 + LAT, 0, 8'h22, 1, 0, 0, 1, 0);
      send(0, frm_a(8'h22, 1'b0), 11, -1); rx_a = 1'b1; idle(4);
      clr_a = 1'b1; expect_at("ovr_clr", cyc + 1, 0, 8'h22, 0, 0, 0, 0, 0);
      @(negedge clk); clr_a = 1'b0; idle(4);

      // Same pair, clear coincides with the second commit: commit wins, no overrun
      send(0, frm_a(8'h11, 1'b0), 11, -1); rx_a = 1'b1; idle(4);
      t0 = cyc + 1;
      expect_at("clr_at_commit", t0 + 171 + LAT, 0, 8'h22, 1, 0, 0, 0, 0);
      send(0, frm_a(8'h22, 1'b0), 11, 170 + LAT); rx_a = 1'b1; idle(4);

      // Reset in the middle of a 0xFF frame
      rx_a = 1'b0; idle(16); rx_a = 1'b1; idle(40);
      rst = 1'b1;
      expect_at("rst_mid_a", cyc + 1, 0, 8'h00, 0, 0, 0, 0, 0);
      expect_at("rst_mid_b", cyc + 1, 1, 8'h00, 0, 0, 0, 0, 0);
      @(negedge clk); rst = 1'b0;
      expect_at("rst_no_commit", cyc + 150, 0, 8'h00, 0, 0, 0, 0, 0);
      idle(160);

      // Clean frame after reset
      t0 = cyc + 1;
      expect_at("post_rst_55", t0 + 171 + LAT, 0, 8'h55, 1, 0, 0, 0, 0);
      send(0, frm_a(8'h55, 1'b0), 11, -1); rx_a = 1'b1; idle(10);

      // Drain, bounded
      for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++; fails++;
         $display("FAIL %s: snapshot for cycle %0d never reached (now %0d)", e.name, e.at, cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
